// File: rtl/bram_read_scheduler_pkg.sv
// Shared definitions for the BRAM read scheduler and the loaders that use it.
// Region bases live here so loaders and the top level agree on addresses.
package bram_read_scheduler_pkg;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_W          = 8;
    localparam int DEF_ADDR_WIDTH = 18;
    localparam int DEF_LEN_WIDTH  = 12;
    localparam int DEF_RD_LAT     = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int unsigned WEIGHT_BASE = 0;
    localparam int unsigned BIAS_BASE   = 147512;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bram_read_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
// Produces a one-hot grant, its index and an any-request flag.
module bram_read_scheduler_rr_arbiter
    import bram_read_scheduler_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int PW    = ptr_width(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PW-1:0]    o_idx,
    output logic             o_any
);

    logic w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && i_req[(int'(i_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                o_grant[(int'(i_ptr) + k) % N_REQ] = 1'b1;
                o_idx = PW'((int'(i_ptr) + k) % N_REQ);
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/bram_read_scheduler.sv
// Shares one read-only BRAM port among several loader clients, serving one
// sequential burst at a time in round-robin order and streaming bytes back.
module bram_read_scheduler
    import bram_read_scheduler_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int W          = DEF_W,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_base,
    input  logic [N_REQ*LEN_WIDTH-1:0]    req_len,
    output logic [N_REQ-1:0]              grant,
    output logic                          data_valid,
    output logic [LEN_WIDTH-1:0]          data_idx,
    output logic [W-1:0]                  data_out,
    output logic [N_REQ-1:0]              done,
    output logic                          busy,
    output logic                          bram_en,
    output logic                          bram_ren,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    input  logic [W-1:0]                  bram_dout
);

    localparam int PW = ptr_width(N_REQ);

    state_t                r_state;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         r_gidx;
    logic [N_REQ-1:0]      r_grant;
    logic [N_REQ-1:0]      r_done;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ren;
    logic [RD_LAT-1:0]     r_vld;
    logic [LEN_WIDTH-1:0]  r_idx [RD_LAT];

    logic [N_REQ-1:0]      w_pick;
    logic [PW-1:0]         w_pidx;
    logic                  w_any;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [LEN_WIDTH-1:0]  w_len;
    logic [RD_LAT-1:0]     w_vld_nxt;

    bram_read_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_idx   (w_pidx),
        .o_any   (w_any)
    );

    assign w_base    = req_base[w_pidx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_len     = req_len[w_pidx*LEN_WIDTH +: LEN_WIDTH];
    // Delay line contents one cycle ahead, no new reads entering in DRAIN.
    assign w_vld_nxt = r_vld << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_ren   <= 1'b0;
            r_vld   <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_idx[k] <= '0;
            end
        end else begin
            r_vld    <= (r_vld << 1) | RD_LAT'(r_ren);
            r_idx[0] <= r_ren ? r_cnt : '0;
            for (int k = 1; k < RD_LAT; k++) begin
                r_idx[k] <= r_idx[k-1];
            end
            r_done <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    r_grant <= '0;
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_gidx  <= w_pidx;
                        r_len   <= w_len;
                        r_cnt   <= '0;
                        if (w_len != '0) begin
                            r_state <= ST_ISSUE;
                            r_ren   <= 1'b1;
                            r_addr  <= w_base;
                        end else begin
                            r_state <= ST_FINISH;
                            r_done  <= w_pick;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_cnt == r_len - LEN_WIDTH'(1)) begin
                        r_state <= ST_DRAIN;
                        r_ren   <= 1'b0;
                        r_addr  <= '0;
                    end else begin
                        r_cnt  <= r_cnt + LEN_WIDTH'(1);
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_vld_nxt == '0) begin
                        r_state <= ST_FINISH;
                        r_done  <= r_grant;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_ptr   <= (r_gidx == PW'(N_REQ - 1)) ? '0
                                                          : r_gidx + PW'(1);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant      = r_grant;
    assign done       = r_done;
    assign busy       = (r_state != ST_IDLE);
    assign bram_ren   = r_ren;
    assign bram_en    = r_ren | (|r_vld);
    assign bram_addr  = r_addr;
    assign data_valid = r_vld[RD_LAT-1];
    assign data_idx   = r_idx[RD_LAT-1];
    assign data_out   = bram_dout;

endmodule

// File: tb/tb_bram_read_scheduler.sv
// Bench for bram_read_scheduler: directed scenarios plus randomized rounds
// checked against a transfer-level model with a behavioural 2-cycle BRAM.
module tb_bram_read_scheduler;
    import bram_read_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int AW = 18;
    localparam int LW = 12;
    localparam int MS = 1 << AW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_base = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    grant;
    logic            data_valid;
    logic [LW-1:0]   data_idx;
    logic [7:0]      data_out;
    logic [N-1:0]    done;
    logic            busy;
    logic            bram_en;
    logic            bram_ren;
    logic [AW-1:0]   bram_addr;
    logic [7:0]      bram_dout = '0;

    logic [7:0] mem [0:MS-1];
    logic [7:0] s1 = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int q_ia[$], q_ic[$], q_vi[$], q_vd[$], q_vc[$], q_dv[$], q_dc[$];

    bram_read_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_base   (req_base),
        .req_len    (req_len),
        .grant      (grant),
        .data_valid (data_valid),
        .data_idx   (data_idx),
        .data_out   (data_out),
        .done       (done),
        .busy       (busy),
        .bram_en    (bram_en),
        .bram_ren   (bram_ren),
        .bram_addr  (bram_addr),
        .bram_dout  (bram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bram_en && bram_ren) s1 <= mem[bram_addr];
        bram_dout <= s1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bram_ren) begin
                q_ia.push_back(int'(bram_addr));
                q_ic.push_back(cyc);
            end
            if (data_valid) begin
                q_vi.push_back(int'(data_idx));
                q_vd.push_back(int'(data_out));
                q_vc.push_back(cyc);
            end
            if (done != '0) begin
                q_dv.push_back(int'(done));
                q_dc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_ia.delete(); q_ic.delete(); q_vi.delete(); q_vd.delete();
        q_vc.delete(); q_dv.delete(); q_dc.delete();
    endtask

    task automatic set_client(input int i, input int base, input int len);
        req_base[i*AW +: AW] = AW'(base);
        req_len[i*LW +: LW]  = LW'(len);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        clear_q();
    endtask

    task automatic wait_dones(input int n, input int bound);
        int b = 0;
        while (q_dv.size() < n && b < bound) begin
            tick();
            b++;
        end
        total++;
        if (q_dv.size() < n) begin
            bad++;
            $display("FAIL done_timeout got=%0d dones need=%0d", q_dv.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (grant !== '0) begin bad++; $display("FAIL rst_grant got=%b exp=0", grant); end
        total++; if (done !== '0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", data_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (bram_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", bram_en); end
        total++; if (bram_ren !== 1'b0) begin bad++; $display("FAIL rst_ren got=%b exp=0", bram_ren); end
        total++; if (bram_addr !== '0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", bram_addr); end
        total++; if (data_idx !== '0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", data_idx); end
    endtask

    task automatic test_single();
        int c0;
        do_reset();
        for (int k = 0; k < 8; k++) mem[BIAS_BASE + k] = 8'h10 + 8'(k);
        set_client(0, BIAS_BASE, 8);
        req = 4'b0001;
        c0 = cyc;
        tick();
        req = '0;
        wait_dones(1, 60);
        total++;
        if (q_ia.size() != 8) begin bad++; $display("FAIL single_nissue got=%0d exp=8", q_ia.size()); end
        foreach (q_ia[k]) begin
            total++;
            if (q_ia[k] != BIAS_BASE + k || q_ic[k] != c0 + 1 + k) begin
                bad++;
                $display("FAIL single_issue k=%0d got=%0d@%0d exp=%0d@%0d",
                         k, q_ia[k], q_ic[k], BIAS_BASE + k, c0 + 1 + k);
            end
        end
        total++;
        if (q_vi.size() != 8) begin bad++; $display("FAIL single_nvalid got=%0d exp=8", q_vi.size()); end
        foreach (q_vi[k]) begin
            total++;
            if (q_vi[k] != k || q_vd[k] != 'h10 + k || q_vc[k] != c0 + 3 + k) begin
                bad++;
                $display("FAIL single_data k=%0d got=%0d/%0h@%0d exp=%0d/%0h@%0d",
                         k, q_vi[k], q_vd[k], q_vc[k], k, 'h10 + k, c0 + 3 + k);
            end
        end
        total++;
        if (q_dv.size() < 1 || q_dv[0] != 1 || q_dc[0] != c0 + 11) begin
            bad++;
            $display("FAIL single_done got=%0d@%0d exp=1@%0d",
                     q_dv.size() ? q_dv[0] : -1, q_dc.size() ? q_dc[0] : -1, c0 + 11);
        end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
    endtask

    task automatic test_contention();
        do_reset();
        set_client(0, 1000, 3);
        set_client(2, 2000, 3);
        req = 4'b0101;
        wait_dones(1, 40);
        total++; if (q_dv[0] != 1) begin bad++; $display("FAIL cont_first got=%0d exp=1", q_dv[0]); end
        req = 4'b0100;
        wait_dones(2, 40);
        total++; if (q_dv[1] != 4) begin bad++; $display("FAIL cont_second got=%0d exp=4", q_dv[1]); end
        total++;
        if (q_ic.size() < 4 || q_ic[3] != q_dc[0] + 2 || q_ia[3] != 2000) begin
            bad++;
            $display("FAIL cont_start got=%0d@%0d exp=2000@%0d",
                     q_ia.size() > 3 ? q_ia[3] : -1, q_ic.size() > 3 ? q_ic[3] : -1, q_dc[0] + 2);
        end
        req = 4'b0101;
        wait_dones(3, 40);
        total++; if (q_dv[2] != 1) begin bad++; $display("FAIL cont_wrap got=%0d exp=1", q_dv[2]); end
        req = 4'b0010;
        wait_dones(4, 40);
        total++; if (q_dv[3] != 2) begin bad++; $display("FAIL cont_one got=%0d exp=2", q_dv[3]); end
        req = 4'b0110;
        wait_dones(5, 40);
        total++; if (q_dv[4] != 4) begin bad++; $display("FAIL cont_fair got=%0d exp=4", q_dv[4]); end
        req = '0;
        repeat (4) tick();
    endtask

    task automatic test_zero();
        int ng = 0, nr = 0, nv = 0, nd = 0;
        do_reset();
        set_client(3, 500, 0);
        req = 4'b1000;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (t == 0) req = '0;
            if (grant[3]) ng++;
            if (bram_ren) nr++;
            if (data_valid) nv++;
            if (done[3]) nd++;
        end
        total++; if (ng != 2) begin bad++; $display("FAIL zero_grant got=%0d exp=2", ng); end
        total++; if (nr != 0) begin bad++; $display("FAIL zero_ren got=%0d exp=0", nr); end
        total++; if (nv != 0) begin bad++; $display("FAIL zero_valid got=%0d exp=0", nv); end
        total++; if (nd != 1) begin bad++; $display("FAIL zero_done got=%0d exp=1", nd); end
    endtask

    task automatic test_wrap();
        int b = MS - 2;
        do_reset();
        set_client(2, b, 4);
        req = 4'b0100;
        tick();
        req = '0;
        wait_dones(1, 40);
        total++;
        if (q_ia.size() != 4 || q_vi.size() != 4) begin
            bad++;
            $display("FAIL wrap_count got=%0d/%0d exp=4/4", q_ia.size(), q_vi.size());
        end
        foreach (q_ia[k]) begin
            total++;
            if (q_ia[k] != (b + k) % MS) begin
                bad++;
                $display("FAIL wrap_addr k=%0d got=%0d exp=%0d", k, q_ia[k], (b + k) % MS);
            end
        end
        foreach (q_vd[k]) begin
            total++;
            if (q_vd[k] != int'(mem[(b + k) % MS]) || q_vi[k] != k) begin
                bad++;
                $display("FAIL wrap_data k=%0d got=%0h exp=%0h", k, q_vd[k], mem[(b + k) % MS]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b = 0;
        do_reset();
        set_client(1, 3000, 8);
        req = 4'b0010;
        tick();
        req = '0;
        while (q_ia.size() < 3 && b < 20) begin
            tick();
            b++;
        end
        rst = 1'b1;
        tick();
        total++;
        if ({grant, done, data_valid, busy, bram_en, bram_ren, bram_addr, data_idx} !== '0) begin
            bad++;
            $display("FAIL rmid_outputs got=%b/%b/%b/%b/%b/%b/%0d/%0d exp=all0",
                     grant, done, data_valid, busy, bram_en, bram_ren, bram_addr, data_idx);
        end
        rst = 1'b0;
        clear_q();
        repeat (6) tick();
        total++;
        if (q_vi.size() != 0 || q_dv.size() != 0) begin
            bad++;
            $display("FAIL rmid_quiet got=%0d valids %0d dones exp=0", q_vi.size(), q_dv.size());
        end
        req = 4'b0010;
        tick();
        req = '0;
        wait_dones(1, 40);
        total++;
        if (q_vi.size() != 8) begin bad++; $display("FAIL rmid_nvalid got=%0d exp=8", q_vi.size()); end
        foreach (q_vi[k]) begin
            total++;
            if (q_vi[k] != k || q_vd[k] != int'(mem[3000 + k])) begin
                bad++;
                $display("FAIL rmid_data k=%0d got=%0d/%0h exp=%0d/%0h", k, q_vi[k], q_vd[k], k, mem[3000 + k]);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        set_client(1, 4000, 5);
        req = 4'b0010;
        tick();
        tick();
        req = '0;
        wait_dones(1, 40);
        total++; if (q_vi.size() != 5) begin bad++; $display("FAIL drop_nvalid got=%0d exp=5", q_vi.size()); end
        total++; if (q_dv[0] != 2) begin bad++; $display("FAIL drop_done got=%0d exp=2", q_dv[0]); end
    endtask

    task automatic test_random();
        int bases[N];
        int lens[N];
        int mptr = 0;
        int w;
        logic [N-1:0] mask;
        do_reset();
        for (int i = 0; i < N; i++) begin
            bases[i] = $urandom_range(0, MS - 1);
            lens[i]  = $urandom_range(0, 6);
            set_client(i, bases[i], lens[i]);
        end
        mask = N'($urandom_range(1, (1 << N) - 1));
        req = mask;
        for (int r = 0; r < 24; r++) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && mask[(mptr + k) % N]) w = (mptr + k) % N;
            end
            wait_dones(1, 40);
            total++;
            if (q_dv[0] != (1 << w)) begin
                bad++;
                $display("FAIL rnd_winner r=%0d got=%0d exp=%0d", r, q_dv[0], 1 << w);
            end
            total++;
            if (q_vi.size() != lens[w] || q_ia.size() != lens[w]) begin
                bad++;
                $display("FAIL rnd_count r=%0d got=%0d/%0d exp=%0d", r, q_vi.size(), q_ia.size(), lens[w]);
            end
            foreach (q_vi[k]) begin
                total++;
                if (q_vi[k] != k || q_vd[k] != int'(mem[(bases[w] + k) % MS])
                    || q_ia[k] != (bases[w] + k) % MS) begin
                    bad++;
                    $display("FAIL rnd_data r=%0d k=%0d got=%0d/%0h/%0d exp=%0d/%0h/%0d", r, k,
                             q_vi[k], q_vd[k], q_ia[k], k, mem[(bases[w] + k) % MS], (bases[w] + k) % MS);
                end
            end
            mptr = (w + 1) % N;
            if ($urandom_range(0, 1) == 0) mask[w] = 1'b0;
            mask = mask | N'($urandom_range(0, (1 << N) - 1) & $urandom_range(0, (1 << N) - 1));
            if (mask == '0) mask[$urandom_range(0, N - 1)] = 1'b1;
            bases[w] = $urandom_range(0, MS - 1);
            lens[w]  = $urandom_range(0, 6);
            set_client(w, bases[w], lens[w]);
            req = mask;
            clear_q();
        end
        req = '0;
        repeat (12) tick();
    endtask

    initial begin
        for (int i = 0; i < MS; i++) mem[i] = 8'((i * 7) + ((i >> 8) * 13) + 3);
        test_reset();
        test_single();
        test_contention();
        test_zero();
        test_wrap();
        test_reset_mid();
        test_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
